// File: rtl/serial_src_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_src_pkg
//  Description : Shared types and helpers for the serial bit source.
//                state_t - shifter state (IDLE, SHIFT)
//                cnt_w   - bit-counter width for a given word width
//  Revision    : 1.0  initial release
// ============================================================================
package serial_src_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter only ever needs to reach WIDTH-1; guard keeps the width at
    // least one bit so the declaration stays legal for tiny words.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : serial_src_pkg
`default_nettype wire

// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_source
//  Description : Parallel-in / serial-out stage feeding a serial sequence
//                detector. Accepts WIDTH-bit words over valid/ready and
//                emits them one bit per clock on x, back to back with no gap.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                in_data    - parallel word, sampled on the accepting edge
//                in_valid   - upstream offers in_data
//                in_ready   - word can be accepted this cycle
//                x          - serial bit out
//                x_valid    - x carries a data bit this cycle
//                frame_done - x carries the last bit of a word
//                busy       - shifter is in SHIFT
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_source
    import serial_src_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            c_cnt_w    = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_out_bit;
    logic               w_last;
    logic               w_accept;

    // The output bit always sits at one end of the register; the register
    // moves the next bit into that position each cycle.
    if (MSB_FIRST) begin : g_msb_first
        assign w_out_bit = r_shift[WIDTH-1];
        assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_out_bit = r_shift[0];
        assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;

        w_last   = (r_state == SHIFT) && (r_cnt == c_last_cnt);
        // Ready depends only on registered state and rst so that it can
        // never form a loop with an upstream valid that looks at ready.
        in_ready = !rst && ((r_state == IDLE) || w_last);
        w_accept = in_valid && in_ready;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = in_data;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (w_accept) begin
                        // Reload on the last bit keeps x_valid continuous.
                        w_shift_nxt = in_data;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        x          = (r_state == SHIFT) ? w_out_bit : IDLE_BIT;
        x_valid    = (r_state == SHIFT);
        busy       = (r_state == SHIFT);
        frame_done = w_last;
    end

endmodule : serial_bit_source
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_bit_source
//  Description : Self-checking bench for serial_bit_source. Two instances
//                (MSB-first and LSB-first) share one stimulus stream and are
//                compared against a bit-queue reference model, plus directed
//                word tables and multi-cycle corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_bit_source;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic rdy_m, x_m, xv_m, fd_m, busy_m;
    logic rdy_l, x_l, xv_l, fd_l, busy_l;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .frame_done(fd_m), .busy(busy_m)
    );

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .frame_done(fd_l), .busy(busy_l)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queues of bits still to be sent ----
    bit q_m[$];
    bit q_l[$];
    bit m_acc = 1'b0;

    function automatic bit model_ready();
        return !rst && (q_m.size() <= 1);
    endfunction

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            m_acc = in_valid && (q_m.size() <= 1);
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (m_acc) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(in_data[i]);
                for (int i = 0; i < W; i++)      q_l.push_back(in_data[i]);
            end
        end
    end

    // {x, x_valid, frame_done, busy, in_ready} compared every cycle.
    always @(negedge clk) begin
        logic [4:0] exp_m, exp_l;
        bit         er;
        er    = model_ready();
        exp_m = {(q_m.size() > 0) ? q_m[0] : 1'b0, q_m.size() > 0, q_m.size() == 1,
                 q_m.size() > 0, er};
        exp_l = {(q_l.size() > 0) ? q_l[0] : 1'b0, q_l.size() > 0, q_l.size() == 1,
                 q_l.size() > 0, er};
        chk("model_msb", {11'd0, x_m, xv_m, fd_m, busy_m, rdy_m}, {11'd0, exp_m});
        chk("model_lsb", {11'd0, x_l, xv_l, fd_l, busy_l, rdy_l}, {11'd0, exp_l});
    end

    // ---------------- directed helpers ------------------------------------
    task automatic wait_accept(input logic [W-1:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 30; k++) begin
            if (model_ready()) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: word %h never accepted", d);
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        @(negedge clk);
        chk({nm, "_idle"}, {13'd0, x_m, xv_m, busy_m}, 16'd0);
        chk({nm, "_idle_l"}, {13'd0, x_l, xv_l, busy_l}, 16'd0);
    endtask

    task automatic run_word(input logic [W-1:0] d, input logic [W-1:0] sm, input logic [W-1:0] sl);
        wait_accept(d, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("word_bit_m", {14'd0, x_m, xv_m}, {14'd0, sm[W-1-i], 1'b1});
            chk("word_bit_l", {14'd0, x_l, xv_l}, {14'd0, sl[W-1-i], 1'b1});
            chk("word_fd", {14'd0, fd_m, fd_l}, {14'd0, i == W - 1, i == W - 1});
        end
        chk_idle("word");
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] seq_m;   // bits in time order, first bit at [W-1]
        logic [W-1:0] seq_l;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bb_m, bb_l;

        tbl[0] = '{8'hB0, 8'b10110000, 8'b00001101};
        tbl[1] = '{8'h0D, 8'b00001101, 8'b10110000};
        tbl[2] = '{8'h81, 8'b10000001, 8'b10000001};
        tbl[3] = '{8'h55, 8'b01010101, 8'b10101010};
        tbl[4] = '{8'hFF, 8'b11111111, 8'b11111111};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {11'd0, x_m, xv_m, fd_m, busy_m, rdy_m}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {14'd0, rdy_m, rdy_l}, 16'd3);

        // Table of single words from idle
        for (int t = 0; t < 5; t++) run_word(tbl[t].data, tbl[t].seq_m, tbl[t].seq_l);

        // Back-to-back: BB then 0B with valid held
        bb_m = 16'b1011101100001011;
        bb_l = 16'b1101110111010000;
        wait_accept(8'hBB, 1'b1);
        in_data = 8'h0B;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("b2b_m", {14'd0, x_m, xv_m}, {14'd0, bb_m[15-i], 1'b1});
            chk("b2b_l", {14'd0, x_l, xv_l}, {14'd0, bb_l[15-i], 1'b1});
            chk("b2b_fd_rdy", {14'd0, fd_m, rdy_m},
                {14'd0, (i == 7) || (i == 15), (i == 7) || (i == 15)});
            if (i == 7) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        chk_idle("b2b");

        // Backpressure: 55 offered from T+2 while 81 is shifting
        wait_accept(8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_first_m", {14'd0, x_m, rdy_m}, {14'd0, tbl[2].seq_m[7-i], i == 7});
            chk("bp_first_l", {15'd0, x_l}, {15'd0, tbl[2].seq_l[7-i]});
            if (i == 0) begin
                @(posedge clk); #1;
                in_valid = 1'b1;
                in_data  = 8'h55;
            end else if (i == 7) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_second_m", {14'd0, x_m, xv_m}, {14'd0, tbl[3].seq_m[7-i], 1'b1});
            chk("bp_second_l", {14'd0, x_l, fd_l}, {14'd0, tbl[3].seq_l[7-i], i == 7});
        end
        chk_idle("bp");

        // Reset mid-frame after the third bit of FF
        wait_accept(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_bits", {14'd0, x_m, x_l}, 16'd3);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready_low", {14'd0, rdy_m, rdy_l}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_after", {11'd0, x_m, xv_m, fd_m, busy_m, rdy_m}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rstmid_no_fd", {14'd0, fd_m, xv_m}, 16'd0);
        end
        run_word(tbl[1].data, tbl[1].seq_m, tbl[1].seq_l);

        // Idle gap of five cycles between two words
        run_word(tbl[0].data, tbl[0].seq_m, tbl[0].seq_l);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_idle", {13'd0, x_m, xv_m, xv_l}, 16'd0);
        end
        run_word(tbl[2].data, tbl[2].seq_m, tbl[2].seq_l);

        // Random traffic; per-cycle checks come from the model comparison
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (!(in_valid && !m_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
            end
            rst = ($urandom_range(0, 60) == 0);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_serial_bit_source
`default_nettype wire

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x.
- x feeds the detector's serial input. x_valid marks the cycles that carry real data.
- Supports gapless back-to-back words, so a bit pattern can straddle a word boundary.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_BIT, 0, level driven on x when no word is being shifted.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  parallel word; sampled only on an accepting edge.
- in_valid  input  1  upstream offers in_data; must be held until accepted.
- in_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the detector.
- x_valid  output  1  x carries a data bit this cycle.
- frame_done  output  1  high during the cycle that presents the last bit of a word.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (rst high at an edge):
  - Next cycle: state = IDLE, shift register = 0, bit count = 0.
  - x = IDLE_BIT, x_valid = 0, frame_done = 0, busy = 0.
  - in_ready is forced 0 while rst is high (combinational gate). It is 1 in the first cycle after rst falls.
- Reset mid-frame: the word in flight is dropped. No further bits of it appear, and there is no partial frame_done.
- States:
  - IDLE: x = IDLE_BIT, x_valid = 0, in_ready = 1.
  - SHIFT: x = the current output bit of the shift register, x_valid = 1.
- Accept: occurs on a rising edge where in_valid & in_ready. The word is loaded into the shift register, count = 0, state = SHIFT.
- Latency: the first bit appears on x in the cycle immediately after the accepting edge.
- Bit order:
  - MSB_FIRST = 1: bits in order WIDTH-1 down to 0.
  - MSB_FIRST = 0: bits in order 0 up to WIDTH-1.
- Bit timing: each bit is held exactly one cycle. The count increments each cycle in SHIFT.
- Last-bit cycle (count == WIDTH-1):
  - frame_done = 1 and in_ready = 1.
  - If a word is accepted at the end of this cycle, the next cycle shows that word's first bit. There is no gap and x_valid stays 1.
  - Otherwise the state returns to IDLE, and x_valid = 0 next cycle.
- in_ready = 0 in SHIFT, except during the last-bit cycle.
- in_valid asserted while in_ready = 0 has no effect. in_data changes outside accepting edges are ignored.
- No arithmetic beyond the bit counter. Counter width = $clog2(WIDTH). The counter never passes WIDTH-1 and never wraps.
- All outputs except in_ready are registered or decoded from registered state only. in_ready depends combinationally on state, count and rst only, never on in_valid.

Decomposition:
- Shared package serial_src_pkg:
  - state enum {IDLE, SHIFT}
  - function cnt_w(WIDTH) returning $clog2(WIDTH)
- Single module, no sub-module; the counter and shift register are inline.

Test Plan:
- Single word, WIDTH = 8, MSB_FIRST = 1, in_data = 8'hB0 accepted at edge T:
  - x = 1,0,1,1,0,0,0,0 on cycles T+1..T+8, with x_valid = 1 throughout.
  - frame_done only at T+8; x_valid = 0 and x = 0 at T+9.
  - With the downstream detector attached, its y goes high one cycle after the fourth bit.
- Back-to-back, in_valid held high with 8'hBB then 8'h0B:
  - 16 contiguous valid bits 10111011 00001011, with no x_valid drop at the boundary.
  - frame_done at cycles 8 and 16; the second accept happens on the cycle-8 edge.
- LSB-first, MSB_FIRST = 0, in_data = 8'h0D:
  - x = 1,0,1,1,0,0,0,0.
  - Same timing as the single-word case.
- Backpressure, in_valid held from T+2 (mid-frame) with 8'h55:
  - in_ready = 0 until T+8.
  - Accept occurs on the T+8 edge, and 8'h55's first bit appears at T+9.
  - 8'h55 is not visible before then.
- Reset mid-frame, rst high for one edge after the 3rd bit of 8'hFF:
  - Next cycle x_valid = 0, x = IDLE_BIT, busy = 0, frame_done never pulses.
  - in_ready = 0 while rst is high and 1 the cycle after.
  - A new word is then accepted normally.
- Idle gap, one word followed by in_valid low for 5 cycles:
  - x = IDLE_BIT and x_valid = 0 for the whole gap.
  - The next word starts 1 cycle after its accepting edge.
